// File: rtl/cache_miss_engine_if.sv
// Cache-side miss/fill handshake plus the block memory request bus.
// The engine is the master; the cache controller and main memory sit on the slave side.
interface cache_miss_engine_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int BLOCK_BITS = 256
);
   logic                  miss_valid;
   logic                  miss_ready;
   logic [ADDR_WIDTH-1:0] miss_addr;
   logic                  victim_dirty;
   logic [ADDR_WIDTH-1:0] victim_addr;
   logic [BLOCK_BITS-1:0] victim_data;
   logic                  fill_valid;
   logic                  fill_ready;
   logic [ADDR_WIDTH-1:0] fill_addr;
   logic [BLOCK_BITS-1:0] fill_data;
   logic                  mem_req;
   logic                  mem_rw;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [BLOCK_BITS-1:0] mem_wdata;
   logic                  mem_ready;
   logic                  mem_resp;
   logic [BLOCK_BITS-1:0] mem_rdata;

   modport master (
      input  miss_valid, miss_addr, victim_dirty, victim_addr, victim_data,
      input  fill_ready, mem_ready, mem_resp, mem_rdata,
      output miss_ready, fill_valid, fill_addr, fill_data,
      output mem_req, mem_rw, mem_addr, mem_wdata
   );

   modport slave (
      output miss_valid, miss_addr, victim_dirty, victim_addr, victim_data,
      output fill_ready, mem_ready, mem_resp, mem_rdata,
      input  miss_ready, fill_valid, fill_addr, fill_data,
      input  mem_req, mem_rw, mem_addr, mem_wdata
   );
endinterface

// File: rtl/cache_miss_engine.sv
// Single-miss engine: optional dirty-victim writeback, then block refill returned to the cache.
// A watchdog aborts any memory wait that exceeds TIMEOUT_CYCLES.
module cache_miss_engine #(
   parameter int ADDR_WIDTH     = 32,
   parameter int BLOCK_BITS     = 256,
   parameter int OFFSET_BITS    = 5,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   cache_miss_engine_if.master bus,
   output logic                err,
   output logic [15:0]         refill_cnt,
   output logic [15:0]         wb_cnt
);
   localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
      ~ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

   typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, FILL} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
   logic                  mem_req_q, mem_req_d, mem_rw_q, mem_rw_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [BLOCK_BITS-1:0] mem_wdata_q, mem_wdata_d;
   logic                  fill_valid_q, fill_valid_d;
   logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
   logic [BLOCK_BITS-1:0] fill_data_q, fill_data_d;
   logic                  err_q, err_d;
   logic [15:0]           refill_cnt_q, refill_cnt_d, wb_cnt_q, wb_cnt_d;
   logic [WD_W-1:0]       wd_q, wd_d;
   logic                  timeout;

   assign timeout        = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
   assign bus.miss_ready = (state_q == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.miss_valid) state_d = bus.victim_dirty ? WB_REQ : RF_REQ;
         WB_REQ:  if (bus.mem_ready) state_d = WB_WAIT;
         RF_REQ:  if (bus.mem_ready) state_d = RF_WAIT;
         // a response arriving on the timeout cycle still completes the phase
         WB_WAIT: if (bus.mem_resp) state_d = RF_REQ; else if (timeout) state_d = IDLE;
         RF_WAIT: if (bus.mem_resp) state_d = FILL;   else if (timeout) state_d = IDLE;
         FILL:    if (bus.fill_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      miss_addr_d  = miss_addr_q;
      mem_req_d    = mem_req_q;
      mem_rw_d     = mem_rw_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      fill_valid_d = fill_valid_q;
      fill_addr_d  = fill_addr_q;
      fill_data_d  = fill_data_q;
      refill_cnt_d = refill_cnt_q;
      wb_cnt_d     = wb_cnt_q;
      err_d        = 1'b0;
      wd_d         = '0;
      unique case (state_q)
         IDLE: if (bus.miss_valid) begin
            miss_addr_d = bus.miss_addr & ALIGN_MASK;
            mem_req_d   = 1'b1;
            if (bus.victim_dirty) begin
               mem_rw_d    = 1'b1;
               mem_addr_d  = bus.victim_addr & ALIGN_MASK;
               mem_wdata_d = bus.victim_data;
            end else begin
               mem_rw_d   = 1'b0;
               mem_addr_d = bus.miss_addr & ALIGN_MASK;
            end
         end
         WB_REQ, RF_REQ: if (bus.mem_ready) mem_req_d = 1'b0;
         WB_WAIT: begin
            wd_d = wd_q + 1'b1;
            if (bus.mem_resp) begin
               if (wb_cnt_q != 16'hFFFF) wb_cnt_d = wb_cnt_q + 16'd1;
               mem_req_d  = 1'b1;
               mem_rw_d   = 1'b0;
               mem_addr_d = miss_addr_q;
            end else if (timeout) begin
               err_d = 1'b1;
            end
         end
         RF_WAIT: begin
            wd_d = wd_q + 1'b1;
            if (bus.mem_resp) begin
               if (refill_cnt_q != 16'hFFFF) refill_cnt_d = refill_cnt_q + 16'd1;
               fill_data_d  = bus.mem_rdata;
               fill_addr_d  = miss_addr_q;
               fill_valid_d = 1'b1;
            end else if (timeout) begin
               err_d = 1'b1;
            end
         end
         FILL: if (bus.fill_ready) fill_valid_d = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         miss_addr_q  <= '0;
         mem_req_q    <= 1'b0;
         mem_rw_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         fill_valid_q <= 1'b0;
         fill_addr_q  <= '0;
         fill_data_q  <= '0;
         err_q        <= 1'b0;
         refill_cnt_q <= '0;
         wb_cnt_q     <= '0;
         wd_q         <= '0;
      end else begin
         miss_addr_q  <= miss_addr_d;
         mem_req_q    <= mem_req_d;
         mem_rw_q     <= mem_rw_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         fill_valid_q <= fill_valid_d;
         fill_addr_q  <= fill_addr_d;
         fill_data_q  <= fill_data_d;
         err_q        <= err_d;
         refill_cnt_q <= refill_cnt_d;
         wb_cnt_q     <= wb_cnt_d;
         wd_q         <= wd_d;
      end
   end

   assign bus.mem_req    = mem_req_q;
   assign bus.mem_rw     = mem_rw_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.fill_valid = fill_valid_q;
   assign bus.fill_addr  = fill_addr_q;
   assign bus.fill_data  = fill_data_q;
   assign err            = err_q;
   assign refill_cnt     = refill_cnt_q;
   assign wb_cnt         = wb_cnt_q;
endmodule

// File: tb/tb_cache_miss_engine.sv
// Scoreboard bench: stimulus pushes expected memory requests, fills and aborts;
// one negedge monitor pops and compares whatever the engine presents.
module tb_cache_miss_engine;
   localparam int AW = 32;
   localparam int BB = 256;
   localparam int TO = 64;

   typedef struct { logic rw; logic [AW-1:0] addr; logic [BB-1:0] wdata; } req_t;
   typedef struct { logic [AW-1:0] addr; logic [BB-1:0] data; } fill_t;

   logic clk = 1'b0, rst_n = 1'b0, err;
   logic [15:0] refill_cnt, wb_cnt;

   cache_miss_engine_if #(.ADDR_WIDTH(AW), .BLOCK_BITS(BB)) bus ();

   cache_miss_engine #(.ADDR_WIDTH(AW), .BLOCK_BITS(BB), .OFFSET_BITS(5), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .err(err),
      .refill_cnt(refill_cnt), .wb_cnt(wb_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0, cyc = 0, rd_acc_cyc = 0;
   int ref_rf = 0, ref_wb = 0;
   bit busy = 0;
   req_t  exp_req[$];
   fill_t exp_fill[$];
   int    exp_err[$];
   logic [BB-1:0] rmem   [logic [AW-1:0]];  // memory seen by the responder
   logic [BB-1:0] mdl_mem[logic [AW-1:0]];  // reference model's view of memory

   bit no_resp = 0, fr_force = 0, fr_val = 0;
   int rdy_force = -1, lat_force = -1;

   task automatic chk(input string nm, input logic [BB-1:0] act, input logic [BB-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
      return a & ~32'h1F;
   endfunction

   function automatic logic [BB-1:0] init_blk(input logic [AW-1:0] a);
      logic [BB-1:0] b;
      for (int k = 0; k < 8; k++) b[32*k +: 32] = a + 32'(4*k);
      return b;
   endfunction

   function automatic logic [BB-1:0] rnd_blk();
      logic [BB-1:0] b;
      for (int k = 0; k < 8; k++) b[32*k +: 32] = $urandom;
      return b;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // memory responder: random accept delay and response latency unless forced
   initial begin : responder
      bit acc, pending, a_rw, p_rw;
      logic [AW-1:0] a_addr, p_addr;
      logic [BB-1:0] a_wd, p_wd;
      int lat, rdy_wait;
      pending = 0; rdy_wait = -1; lat = 0; p_rw = 0; p_addr = '0; p_wd = '0;
      bus.mem_ready = 0; bus.mem_resp = 0; bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         acc = rst_n && bus.mem_req && bus.mem_ready;
         a_rw = bus.mem_rw; a_addr = bus.mem_addr; a_wd = bus.mem_wdata;
         @(posedge clk); #1;
         bus.mem_ready = 0; bus.mem_resp = 0;
         if (acc) begin
            rdy_wait = -1;
            if (!no_resp) begin
               pending = 1; p_rw = a_rw; p_addr = a_addr; p_wd = a_wd;
               lat = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 5));
            end
         end else if (pending) begin
            if (lat == 0) begin
               bus.mem_resp = 1;
               if (p_rw) rmem[p_addr] = p_wd;
               else bus.mem_rdata = rmem.exists(p_addr) ? rmem[p_addr] : init_blk(p_addr);
               pending = 0;
            end else lat--;
         end
         if (!rst_n) rdy_wait = -1;
         else if (bus.mem_req && !pending && !acc) begin
            if (rdy_wait < 0) rdy_wait = (rdy_force >= 0) ? rdy_force : int'($urandom_range(0, 3));
            if (rdy_wait == 0) bus.mem_ready = 1;
            else rdy_wait--;
         end
      end
   end

   initial begin : fill_ready_drv
      bus.fill_ready = 0;
      forever begin
         @(posedge clk); #1;
         bus.fill_ready = fr_force ? fr_val : ($urandom_range(0, 2) != 0);
      end
   end

   initial begin : monitor
      bit prev_req, prev_rdy, prev_rw, prev_fv, prev_fr;
      logic [AW-1:0] prev_ma, prev_fa;
      logic [BB-1:0] prev_wd, prev_fd;
      req_t r; fill_t f;
      prev_req = 0; prev_rdy = 0; prev_rw = 0; prev_fv = 0; prev_fr = 0;
      prev_ma = '0; prev_fa = '0; prev_wd = '0; prev_fd = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy = 0; prev_req = 0; prev_fv = 0;
         end else begin
            if (err) begin
               busy = 0;
               if (exp_err.size() == 0) chk("err_unexpected", 1, 0);
               else begin
                  void'(exp_err.pop_front());
                  chk("err_latency", BB'(cyc - rd_acc_cyc), BB'(TO));
               end
            end
            chk("miss_ready", bus.miss_ready, !busy);
            if (prev_req && !prev_rdy) begin
               chk("req_hold", {bus.mem_req, bus.mem_rw, bus.mem_addr}, {1'b1, prev_rw, prev_ma});
               if (prev_rw) chk("wdata_hold", bus.mem_wdata, prev_wd);
            end
            if (prev_fv && !prev_fr)
               chk("fill_hold", {bus.fill_valid, bus.fill_addr, bus.fill_data}, {1'b1, prev_fa, prev_fd});
            if (bus.mem_req && bus.mem_ready) begin
               if (exp_req.size() == 0) chk("req_unexpected", 1, 0);
               else begin
                  r = exp_req.pop_front();
                  chk("req_rw_addr", {bus.mem_rw, bus.mem_addr}, {r.rw, r.addr});
                  if (r.rw) chk("req_wdata", bus.mem_wdata, r.wdata);
               end
               if (!bus.mem_rw) rd_acc_cyc = cyc + 1;
            end
            if (bus.fill_valid && bus.fill_ready) begin
               busy = 0;
               if (exp_fill.size() == 0) chk("fill_unexpected", 1, 0);
               else begin
                  f = exp_fill.pop_front();
                  chk("fill_addr", bus.fill_addr, f.addr);
                  chk("fill_data", bus.fill_data, f.data);
               end
            end
            if (bus.miss_valid && bus.miss_ready) busy = 1;
            prev_req = bus.mem_req;    prev_rdy = bus.mem_ready; prev_rw = bus.mem_rw;
            prev_ma  = bus.mem_addr;   prev_wd  = bus.mem_wdata;
            prev_fv  = bus.fill_valid; prev_fr  = bus.fill_ready;
            prev_fa  = bus.fill_addr;  prev_fd  = bus.fill_data;
         end
      end
   end

   // model: push what the engine must do for this miss, then present it until accepted
   task automatic issue_miss(input logic [AW-1:0] a, input bit dirty, input logic [AW-1:0] va,
                             input logic [BB-1:0] vd, input bit completes);
      bit ok;
      if (dirty) begin
         exp_req.push_back('{1'b1, align(va), vd});
         mdl_mem[align(va)] = vd;
         ref_wb++;
      end
      exp_req.push_back('{1'b0, align(a), '0});
      if (completes) begin
         exp_fill.push_back('{align(a), mdl_mem.exists(align(a)) ? mdl_mem[align(a)] : init_blk(align(a))});
         ref_rf++;
      end else exp_err.push_back(1);
      @(posedge clk); #1;
      bus.miss_valid = 1; bus.miss_addr = a; bus.victim_dirty = dirty;
      bus.victim_addr = va; bus.victim_data = vd;
      ok = 0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         ok = bus.miss_ready;
      end
      if (!ok) chk("miss_accept_timeout", 0, 1);
      @(posedge clk); #1;
      bus.miss_valid = 0;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge clk);
         ok = !busy;
      end
      if (!ok) chk("idle_timeout", 0, 1);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_mem_req", bus.mem_req, 0);       chk("rst_mem_rw", bus.mem_rw, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);     chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_fill_valid", bus.fill_valid, 0); chk("rst_fill_addr", bus.fill_addr, 0);
      chk("rst_fill_data", bus.fill_data, 0);   chk("rst_err", err, 0);
      chk("rst_refill_cnt", refill_cnt, 0);     chk("rst_wb_cnt", wb_cnt, 0);
      chk("rst_miss_ready", bus.miss_ready, 1);
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL global_timeout: got running expected finished");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "bench timeout");
   end

   initial begin : stim
      logic [BB-1:0] dead;
      bit ok;
      bus.miss_valid = 0; bus.miss_addr = '0; bus.victim_dirty = 0;
      bus.victim_addr = '0; bus.victim_data = '0;
      repeat (3) @(posedge clk);
      #1 chk_reset_outputs();
      rst_n = 1;

      // clean miss
      rdy_force = 0; lat_force = 2;
      issue_miss(32'h124, 0, '0, '0, 1);
      wait_idle();
      chk("clean_refill_cnt", refill_cnt, BB'(ref_rf));
      chk("clean_wb_cnt", wb_cnt, 0);

      // dirty miss, then read back the written victim
      for (int k = 0; k < 8; k++) dead[32*k +: 32] = 32'hDEAD_0000 + 32'(k);
      issue_miss(32'h400, 1, 32'h205, dead, 1);
      wait_idle();
      issue_miss(32'h200, 0, '0, '0, 1);
      wait_idle();
      chk("dirty_wb_cnt", wb_cnt, BB'(ref_wb));
      chk("dirty_refill_cnt", refill_cnt, BB'(ref_rf));

      // fill backpressure with a second miss waiting
      fr_val = 0; fr_force = 1;
      issue_miss(32'h660, 0, '0, '0, 1);
      fork
         begin
            ok = 0;
            for (int i = 0; i < 200 && !ok; i++) begin
               @(negedge clk);
               ok = bus.fill_valid;
            end
            if (!ok) chk("bp_fill_timeout", 0, 1);
            repeat (4) @(negedge clk);
            fr_val = 1;
            @(negedge clk);
            fr_val = 0;
         end
         issue_miss(32'h780, 0, '0, '0, 1);
      join
      fr_force = 0;
      wait_idle();

      // memory holds off each request for 3 cycles
      rdy_force = 3;
      issue_miss(32'h8A0, 1, 32'h9C0, rnd_blk(), 1);
      wait_idle();
      chk("hold_wb_cnt", wb_cnt, BB'(ref_wb));

      // timeout: memory never responds
      rdy_force = 0; no_resp = 1;
      issue_miss(32'hA00, 0, '0, '0, 0);
      wait_idle();
      no_resp = 0;
      chk("timeout_refill_cnt", refill_cnt, BB'(ref_rf));
      chk("timeout_no_pending", BB'(exp_err.size()), 0);

      // reset while waiting for a refill; its late response must be ignored
      lat_force = 20;
      issue_miss(32'hB40, 0, '0, '0, 1);
      repeat (5) @(posedge clk);
      #1 rst_n = 0;
      exp_fill.delete(); exp_req.delete(); ref_rf = 0; ref_wb = 0;
      #1 chk_reset_outputs();
      @(posedge clk); #1 rst_n = 1;
      repeat (30) @(posedge clk);
      lat_force = -1;
      issue_miss(32'hC20, 0, '0, '0, 1);
      wait_idle();
      chk("post_reset_refill_cnt", refill_cnt, BB'(ref_rf));

      // random traffic
      rdy_force = -1;
      for (int n = 0; n < 40; n++) begin
         issue_miss(32'h1000 + 32'($urandom_range(0, 255)), $urandom_range(0, 1) == 1,
                    32'h1000 + 32'($urandom_range(0, 255)), rnd_blk(), 1);
         if ($urandom_range(0, 1) == 1) wait_idle();
      end
      wait_idle();
      chk("final_refill_cnt", refill_cnt, BB'(ref_rf));
      chk("final_wb_cnt", wb_cnt, BB'(ref_wb));
      chk("final_req_q_empty", BB'(exp_req.size()), 0);
      chk("final_fill_q_empty", BB'(exp_fill.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cache_miss_engine.md
Name: cache_miss_engine

Overview:
- Cache-side initiator for the block memory interface. Accepts one miss at a time from the cache controller.
- On a dirty victim, writes the 32-byte victim block back to main memory first, then issues a block refill read.
- Returns the refill block to the cache with a valid/ready handshake.
- Owns the mem_req/mem_rw/mem_addr/mem_wdata side of the interface whose responder is main memory.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- BLOCK_BITS, 256, cache block width (8 x 32-bit words).
- OFFSET_BITS, 5, block offset bits, zeroed on every outgoing address.
- TIMEOUT_CYCLES, 64, max cycles in a wait state before abort.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- miss_valid  in  1  cache presents a miss
- miss_ready  out  1  engine can accept a miss
- miss_addr  in  ADDR_WIDTH  missing byte address
- victim_dirty  in  1  victim block must be written back
- victim_addr  in  ADDR_WIDTH  victim block address
- victim_data  in  BLOCK_BITS  victim block data
- fill_valid  out  1  refill block available
- fill_ready  in  1  cache consumes refill block
- fill_addr  out  ADDR_WIDTH  block-aligned refill address
- fill_data  out  BLOCK_BITS  refill block, word 0 in [31:0]
- err  out  1  one-cycle pulse on timeout abort
- mem_req  out  1  memory request
- mem_rw  out  1  0 = read, 1 = write
- mem_addr  out  ADDR_WIDTH  block-aligned memory address
- mem_wdata  out  BLOCK_BITS  writeback data
- mem_ready  in  1  memory accepts a request
- mem_resp  in  1  one-cycle completion pulse
- mem_rdata  in  BLOCK_BITS  read block, valid while mem_resp = 1
- refill_cnt  out  16  completed refills, saturating
- wb_cnt  out  16  completed writebacks, saturating

Behaviour:
- Reset (async, rst_n = 0): state IDLE. All registered outputs are 0: mem_req, mem_rw, mem_addr, mem_wdata, fill_valid, fill_addr, fill_data, err, refill_cnt, wb_cnt. Watchdog counter cleared.
- Reset mid-operation: any transaction in flight is abandoned. No fill is produced.
- miss_ready = (state == IDLE). It is combinational, so miss_ready = 1 after reset.
- States: IDLE, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, FILL.
- IDLE: on an edge with miss_valid && miss_ready, latch the aligned miss address, victim_addr and victim_data.
  - victim_dirty = 1: go to WB_REQ; mem_req <= 1, mem_rw <= 1, mem_addr <= aligned victim_addr, mem_wdata <= victim_data.
  - victim_dirty = 0: go to RF_REQ; mem_req <= 1, mem_rw <= 0, mem_addr <= aligned miss_addr.
- Address alignment: outgoing and fill addresses always have [OFFSET_BITS-1:0] = 0.
- WB_REQ / RF_REQ: hold mem_req, mem_rw, mem_addr and mem_wdata stable. On an edge with mem_ready = 1: mem_req <= 0, clear the watchdog, go to the matching WAIT state. Never more than one outstanding request.
- WB_WAIT: on mem_resp = 1, wb_cnt++ (saturate at 0xFFFF), go to RF_REQ with mem_req <= 1, mem_rw <= 0, mem_addr <= latched miss address.
- RF_WAIT: on mem_resp = 1, fill_data <= mem_rdata, fill_addr <= latched miss address, fill_valid <= 1, refill_cnt++ (saturating), go to FILL.
- mem_resp seen in IDLE, a REQ state or FILL is ignored.
- FILL: fill_valid, fill_addr and fill_data held stable until an edge with fill_ready = 1. Then fill_valid <= 0 and go to IDLE. The earliest next miss is accepted one cycle later.
- Watchdog: increments every cycle in WB_WAIT/RF_WAIT. If it reaches TIMEOUT_CYCLES-1 with no mem_resp, then err <= 1 for one cycle, go to IDLE, and no fill or count update occurs.
- Simultaneous mem_resp and timeout in the same cycle: the response wins.
- Latency: mem_req rises 1 cycle after miss acceptance. fill_valid rises 1 cycle after the refill mem_resp.

Test Plan:
- Clean miss: miss_addr = 0x0000_0124, victim_dirty = 0, memory initialized with word i = 4*i -> exactly one read with mem_addr = 0x120, mem_rw = 0; fill_addr = 0x120; fill_data words 0..7 = 0x120, 0x124, ..., 0x13C; refill_cnt = 1, wb_cnt = 0.
- Dirty miss: victim_addr = 0x205, victim_data word k = 0xDEAD_0000+k, miss_addr = 0x400 -> write at mem_addr = 0x200 first, then read at 0x400. A later clean miss at 0x200 returns 0xDEAD_0000..0xDEAD_0007. wb_cnt = 1.
- Fill backpressure: fill_ready held low 5 cycles after fill_valid -> fill_valid and fill_data stable for 6 cycles. miss_ready stays 0 throughout, and a miss_valid presented then is not accepted until after the fill handshake.
- Request hold: memory busy, mem_ready = 0 for 3 cycles -> mem_req and mem_addr stay stable. Exactly one accepted request per phase.
- Timeout: responder never asserts mem_resp -> err pulses once, TIMEOUT_CYCLES = 64 cycles after entering RF_WAIT. Then IDLE, no fill_valid, refill_cnt unchanged.
- Reset mid-RF_WAIT: rst_n low for 1 cycle -> all outputs 0 immediately. A late mem_resp is ignored, and a fresh miss completes normally.
